// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_pkg: shared widths, port id type and in-flight record for mem_arbiter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;
  localparam int MAX_RPORTS = 4;
  localparam int PORT_W     = $clog2(MAX_RPORTS);

  typedef logic [PORT_W-1:0] port_id_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_rw;
    port_id_t              port;
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wen;
    logic [MEM_DATA_W-1:0] wdata;
  } inflight_t;

endpackage

`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_rr_arbiter: round-robin pick of the first unmasked request at or after |
// | the pointer; one-hot grant, grant index and advanced pointer out.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_RPORTS = 2
) (
  input  logic [NUM_RPORTS-1:0] req_i,
  input  logic [NUM_RPORTS-1:0] mask_i,
  input  port_id_t              ptr_i,
  output logic [NUM_RPORTS-1:0] gnt_o,
  output port_id_t              gnt_idx_o,
  output port_id_t              next_ptr_o,
  output logic                  any_o
);

  logic [NUM_RPORTS-1:0] eff;

  assign eff = req_i & ~mask_i;

  // Offset i from the pointer maps to port j either directly or after one wrap.
  always_comb begin
    gnt_o      = '0;
    gnt_idx_o  = '0;
    next_ptr_o = ptr_i;
    any_o      = 1'b0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      for (int j = 0; j < NUM_RPORTS; j++) begin
        if (!any_o && eff[j] &&
            ((int'(ptr_i) + i == j) || (int'(ptr_i) + i == j + NUM_RPORTS))) begin
          any_o      = 1'b1;
          gnt_o[j]   = 1'b1;
          gnt_idx_o  = port_id_t'(j);
          next_ptr_o = (j == NUM_RPORTS - 1) ? '0 : port_id_t'(j + 1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter: one-access-per-cycle front end for a sync single-port RAM;    |
// | LSU rw port first, fetch read ports round-robin, response one cycle later. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef MEM_RPORTS
`define MEM_RPORTS 2
`endif

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_RPORTS = `MEM_RPORTS,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  input  logic [NUM_RPORTS-1:0]             r_val_i,
  input  logic [NUM_RPORTS-1:0][ADDR_W-1:0] r_addr_i,
  output logic [NUM_RPORTS-1:0]             r_rdy_o,
  output logic [DATA_W-1:0]                 r_rdata_o,
  input  logic                              rw_val_i,
  input  logic                              rw_wen_i,
  input  logic [ADDR_W-1:0]                 rw_addr_i,
  input  logic [DATA_W-1:0]                 rw_wdata_i,
  output logic                              rw_rdy_o,
  output logic [DATA_W-1:0]                 rw_rdata_o,
  output logic                              ram_en_o,
  output logic                              ram_we_o,
  output logic [ADDR_W-1:0]                 ram_addr_o,
  output logic [DATA_W-1:0]                 ram_wdata_o,
  input  logic [DATA_W-1:0]                 ram_rdata_i
);

  inflight_t             inflight_q, inflight_d;
  port_id_t              rr_ptr_q, rr_ptr_d;

  logic [NUM_RPORTS-1:0] r_mask;
  logic [NUM_RPORTS-1:0] r_gnt;
  port_id_t              r_gnt_idx;
  port_id_t              r_next_ptr;
  logic                  r_any;
  logic                  rw_gnt;
  logic                  ram_en;
  logic                  ram_we;

  // The port whose response lands this cycle sits out issue, so no port is
  // granted back to back and rw can never lock reads out for two cycles.
  assign rw_gnt = rw_val_i && !(inflight_q.valid && inflight_q.is_rw);

  always_comb begin
    r_mask = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      r_mask[i] = inflight_q.valid && !inflight_q.is_rw &&
                  (inflight_q.port == port_id_t'(i));
    end
  end

  mem_rr_arbiter #(
    .NUM_RPORTS (NUM_RPORTS)
  ) u_rr (
    .req_i      (r_val_i),
    .mask_i     (r_mask),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (r_gnt),
    .gnt_idx_o  (r_gnt_idx),
    .next_ptr_o (r_next_ptr),
    .any_o      (r_any)
  );

  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    inflight_d  = '0;
    rr_ptr_d    = rr_ptr_q;
    if (rw_gnt) begin
      ram_en           = 1'b1;
      ram_we           = rw_wen_i;
      ram_addr_o       = rw_addr_i;
      ram_wdata_o      = rw_wdata_i;
      inflight_d.valid = 1'b1;
      inflight_d.is_rw = 1'b1;
      inflight_d.addr  = rw_addr_i;
      inflight_d.wen   = rw_wen_i;
      inflight_d.wdata = rw_wdata_i;
    end else if (r_any) begin
      ram_en = 1'b1;
      for (int j = 0; j < NUM_RPORTS; j++) begin
        if (r_gnt[j]) ram_addr_o = r_addr_i[j];
      end
      inflight_d.valid = 1'b1;
      inflight_d.port  = r_gnt_idx;
      inflight_d.addr  = ram_addr_o;
      rr_ptr_d         = r_next_ptr;
    end
  end

  assign ram_en_o = arst_ni && ram_en;
  assign ram_we_o = arst_ni && ram_we;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      inflight_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // A response is only delivered if the requester still holds the same request.
  always_comb begin
    r_rdy_o = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      r_rdy_o[i] = arst_ni && inflight_q.valid && !inflight_q.is_rw &&
                   (inflight_q.port == port_id_t'(i)) &&
                   r_val_i[i] && (r_addr_i[i] == inflight_q.addr);
    end
  end

  assign rw_rdy_o = arst_ni && inflight_q.valid && inflight_q.is_rw && rw_val_i &&
                    (rw_addr_i == inflight_q.addr) && (rw_wen_i == inflight_q.wen);

  assign r_rdata_o  = ram_rdata_i;
  assign rw_rdata_o = inflight_q.wen ? inflight_q.wdata : ram_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter: scoreboard bench for mem_arbiter with a sync RAM model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  localparam int NR = 2;

  logic               clk_i = 1'b0;
  logic               arst_ni;
  logic [NR-1:0]      r_val_i;
  logic [NR-1:0][7:0] r_addr_i;
  logic [NR-1:0]      r_rdy_o;
  logic [15:0]        r_rdata_o;
  logic               rw_val_i;
  logic               rw_wen_i;
  logic [7:0]         rw_addr_i;
  logic [15:0]        rw_wdata_i;
  logic               rw_rdy_o;
  logic [15:0]        rw_rdata_o;
  logic               ram_en_o;
  logic               ram_we_o;
  logic [7:0]         ram_addr_o;
  logic [15:0]        ram_wdata_o;
  logic [15:0]        ram_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .NUM_RPORTS (NR),
    .ADDR_W     (8),
    .DATA_W     (16)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .r_val_i     (r_val_i),
    .r_addr_i    (r_addr_i),
    .r_rdy_o     (r_rdy_o),
    .r_rdata_o   (r_rdata_o),
    .rw_val_i    (rw_val_i),
    .rw_wen_i    (rw_wen_i),
    .rw_addr_i   (rw_addr_i),
    .rw_wdata_i  (rw_wdata_i),
    .rw_rdy_o    (rw_rdy_o),
    .rw_rdata_o  (rw_rdata_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  function automatic logic [15:0] init_val(input int a);
    case (a)
      8'h01:   return 16'hA001;
      8'h02:   return 16'hA002;
      8'h10:   return 16'h1234;
      8'h30:   return 16'h3030;
      8'h40:   return 16'h4040;
      8'h60:   return 16'h6060;
      default: return {8'hC3, 8'(a)};
    endcase
  endfunction

  // Sync single-port RAM, loaded on its first clock (reset is held then).
  logic [15:0] tb_ram [256];
  logic        ram_loaded = 1'b0;
  always @(posedge clk_i) begin
    if (!ram_loaded) begin
      for (int a = 0; a < 256; a++) tb_ram[a] <= init_val(a);
      ram_loaded <= 1'b1;
    end else if (ram_en_o) begin
      ram_rdata_i <= tb_ram[ram_addr_o];
      if (ram_we_o) tb_ram[ram_addr_o] <= ram_wdata_o;
    end
  end

  logic [15:0] model_mem [256];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [15:0] sb_r0[$];
  logic [15:0] sb_r1[$];
  logic [15:0] sb_rw[$];
  logic        keep_r0 = 1'b0;
  logic        keep_r1 = 1'b0;
  logic        keep_rw = 1'b0;

  // Response monitor: every rdy must match a queued expectation; held requests re-arm.
  always @(negedge clk_i) begin
    logic [15:0] e;
    if (r_rdy_o[0]) begin
      if (sb_r0.size() == 0) chk("r0_unexpected_rdy", 1, 0);
      else begin
        e = sb_r0.pop_front();
        chk("r0_rdata", r_rdata_o, e);
        if (keep_r0) sb_r0.push_back(model_mem[r_addr_i[0]]);
      end
    end
    if (r_rdy_o[1]) begin
      if (sb_r1.size() == 0) chk("r1_unexpected_rdy", 1, 0);
      else begin
        e = sb_r1.pop_front();
        chk("r1_rdata", r_rdata_o, e);
        if (keep_r1) sb_r1.push_back(model_mem[r_addr_i[1]]);
      end
    end
    if (rw_rdy_o) begin
      if (sb_rw.size() == 0) chk("rw_unexpected_rdy", 1, 0);
      else begin
        e = sb_rw.pop_front();
        chk("rw_rdata", rw_rdata_o, e);
        if (keep_rw) sb_rw.push_back(model_mem[rw_addr_i]);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  function automatic int gnt_port();
    case (ram_addr_o)
      8'h01:   return 0;
      8'h02:   return 1;
      8'h60:   return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    int prev;
    int g;
    int last0, last1, gap0, gap1;

    for (int a = 0; a < 256; a++) model_mem[a] = init_val(a);

    // Reset with every request asserted: outputs must stay quiet.
    arst_ni    = 1'b0;
    r_val_i    = 2'b11;
    r_addr_i   = '{8'h02, 8'h01};
    rw_val_i   = 1'b1;
    rw_wen_i   = 1'b1;
    rw_addr_i  = 8'h05;
    rw_wdata_i = 16'h5555;
    smp();
    chk("rst_r_rdy", r_rdy_o, 0);
    chk("rst_rw_rdy", rw_rdy_o, 0);
    chk("rst_ram_en", ram_en_o, 0);
    chk("rst_ram_we", ram_we_o, 0);
    step();
    r_val_i  = '0;
    rw_val_i = 1'b0;
    rw_wen_i = 1'b0;
    step();
    arst_ni = 1'b1;
    step();

    // Single read, no contention: grant now, rdy next cycle only.
    r_val_i[0]  = 1'b1;
    r_addr_i[0] = 8'h10;
    sb_r0.push_back(model_mem[8'h10]);
    smp();
    chk("t1_ram_en", ram_en_o, 1);
    chk("t1_ram_addr", ram_addr_o, 8'h10);
    chk("t1_ram_we", ram_we_o, 0);
    chk("t1_rdy_early", r_rdy_o, 0);
    step();
    smp();
    chk("t1_rdy", r_rdy_o, 2'b01);
    chk("t1_no_regrant", ram_en_o, 0);
    step();
    r_val_i[0] = 1'b0;
    smp();
    chk("t1_rdy_once", r_rdy_o, 0);

    // Two read ports held continuously: strict alternation, one rdy per cycle.
    step();
    r_val_i  = 2'b11;
    r_addr_i = '{8'h02, 8'h01};
    keep_r0  = 1'b1;
    keep_r1  = 1'b1;
    sb_r0.push_back(model_mem[8'h01]);
    sb_r1.push_back(model_mem[8'h02]);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("t2_ram_en", ram_en_o, 1);
      g = gnt_port();
      if (i == 0) chk("t2_first_gnt", g, 1);
      else begin
        chk("t2_alternate", g, 1 - prev);
        chk("t2_one_rdy", $countones(r_rdy_o), 1);
      end
      prev = g;
      if (i < 7) step();
    end
    step();
    r_val_i = '0;
    keep_r0 = 1'b0;
    keep_r1 = 1'b0;
    sb_r0.delete();
    sb_r1.delete();
    step();

    // Write and read to the same word together: rw first, read sees new data.
    rw_val_i    = 1'b1;
    rw_wen_i    = 1'b1;
    rw_addr_i   = 8'h20;
    rw_wdata_i  = 16'hBEEF;
    r_val_i[0]  = 1'b1;
    r_addr_i[0] = 8'h20;
    model_mem[8'h20] = 16'hBEEF;
    sb_rw.push_back(16'hBEEF);
    sb_r0.push_back(model_mem[8'h20]);
    smp();
    chk("t3_w_en", ram_en_o, 1);
    chk("t3_w_we", ram_we_o, 1);
    chk("t3_w_addr", ram_addr_o, 8'h20);
    chk("t3_w_data", ram_wdata_o, 16'hBEEF);
    step();
    smp();
    chk("t3_rw_rdy", rw_rdy_o, 1);
    chk("t3_r_en", ram_en_o, 1);
    chk("t3_r_we", ram_we_o, 0);
    chk("t3_r_addr", ram_addr_o, 8'h20);
    step();
    rw_val_i = 1'b0;
    rw_wen_i = 1'b0;
    smp();
    chk("t3_r_rdy", r_rdy_o, 2'b01);
    step();
    r_val_i[0] = 1'b0;
    smp();
    chk("t3_quiet", r_rdy_o, 0);

    // Address changes while in flight: response dropped, regrant, new data.
    step();
    r_val_i[1]  = 1'b1;
    r_addr_i[1] = 8'h30;
    sb_r1.push_back(model_mem[8'h30]);
    smp();
    chk("t4_gnt_addr", ram_addr_o, 8'h30);
    step();
    r_addr_i[1] = 8'h40;
    void'(sb_r1.pop_back());
    sb_r1.push_back(model_mem[8'h40]);
    smp();
    chk("t4_dropped", r_rdy_o, 0);
    chk("t4_masked", ram_en_o, 0);
    step();
    smp();
    chk("t4_regrant_en", ram_en_o, 1);
    chk("t4_regrant_addr", ram_addr_o, 8'h40);
    chk("t4_no_rdy", r_rdy_o, 0);
    step();
    smp();
    chk("t4_rdy", r_rdy_o, 2'b10);
    step();
    r_val_i[1] = 1'b0;

    // Reset while a read is in flight: no rdy during or after reset.
    r_val_i[0]  = 1'b1;
    r_addr_i[0] = 8'h50;
    smp();
    chk("t5_gnt", ram_en_o, 1);
    step();
    arst_ni = 1'b0;
    smp();
    chk("t5_rst_rdy_a", r_rdy_o, 0);
    chk("t5_rst_en_a", ram_en_o, 0);
    step();
    r_val_i = '0;
    smp();
    chk("t5_rst_rdy_b", r_rdy_o, 0);
    step();
    smp();
    chk("t5_rst_rdy_c", r_rdy_o, 0);
    #1;
    arst_ni = 1'b1;
    step();
    smp();
    chk("t5_post_rdy", r_rdy_o, 0);
    chk("t5_post_en", ram_en_o, 0);

    // Pointer restarts at 0 after reset: simultaneous requests go to port 0 first.
    step();
    r_val_i  = 2'b11;
    r_addr_i = '{8'h02, 8'h01};
    sb_r0.push_back(model_mem[8'h01]);
    sb_r1.push_back(model_mem[8'h02]);
    smp();
    chk("t5_ptr0_gnt", gnt_port(), 0);
    step();
    smp();
    chk("t5_rdy0", r_rdy_o, 2'b01);
    chk("t5_then_p1", gnt_port(), 1);
    step();
    r_val_i[0] = 1'b0;
    smp();
    chk("t5_rdy1", r_rdy_o, 2'b10);
    step();
    r_val_i[1] = 1'b0;
    step();

    // rw held high with both reads pending: nobody repeats, reads never starve.
    rw_val_i  = 1'b1;
    rw_wen_i  = 1'b0;
    rw_addr_i = 8'h60;
    r_val_i   = 2'b11;
    r_addr_i  = '{8'h02, 8'h01};
    keep_rw   = 1'b1;
    keep_r0   = 1'b1;
    keep_r1   = 1'b1;
    sb_rw.push_back(model_mem[8'h60]);
    sb_r0.push_back(model_mem[8'h01]);
    sb_r1.push_back(model_mem[8'h02]);
    prev  = -1;
    last0 = 0;
    last1 = 0;
    gap0  = 0;
    gap1  = 0;
    for (int i = 0; i < 16; i++) begin
      smp();
      chk("t6_ram_en", ram_en_o, 1);
      g = gnt_port();
      if (i > 0) chk("t6_no_repeat", (g != prev), 1);
      if (g == 0) begin
        if (i - last0 > gap0) gap0 = i - last0;
        last0 = i;
      end
      if (g == 1) begin
        if (i - last1 > gap1) gap1 = i - last1;
        last1 = i;
      end
      prev = g;
      if (i < 15) step();
    end
    if (15 - last0 > gap0) gap0 = 15 - last0;
    if (15 - last1 > gap1) gap1 = 15 - last1;
    chk("t6_gap_port0", (gap0 <= 2 * NR), 1);
    chk("t6_gap_port1", (gap1 <= 2 * NR), 1);
    step();
    rw_val_i = 1'b0;
    r_val_i  = '0;
    keep_rw  = 1'b0;
    keep_r0  = 1'b0;
    keep_r1  = 1'b0;
    sb_rw.delete();
    sb_r0.delete();
    sb_r1.delete();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("idle_r_rdy", r_rdy_o, 0);
      chk("idle_rw_rdy", rw_rdy_o, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
